hazard_controller: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. It drives the Execute-stage forwarding mux selects, detects load-use hazards, and flushes after a taken branch or jump. It also sequences the iterative multiply/divide unit that sits beside the Execute ALU, holding the front of the pipeline while that unit is busy, and keeps stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_controller_if.sv | 31 +++
 rtl/hazard_controller_forward_sel.sv | 23 ++
 rtl/hazard_controller.sv | 120 ++++++++++++
 tb/tb_hazard_controller.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle between the datapath and the hazard controller.
interface hazard_controller_if #(parameter int CNT_W = 32);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [1:0]       ResultSrcE;
    logic [4:0]       RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic             PCSrcE;
    logic             MdReqE;
    logic             MdDoneE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;
    logic             MdStartE;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, RdM, RdW,
               RegWriteM, RegWriteW, PCSrcE, MdReqE, MdDoneE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MdStartE, StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, RdM, RdW,
               RegWriteM, RegWriteW, PCSrcE, MdReqE, MdDoneE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MdStartE, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_controller_forward_sel.sv
// Execute-stage operand forwarding select for one source operand.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output fwd_sel_t   select
);

    // Memory stage holds the younger result, so it wins over Writeback.
    always_comb begin
        select = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
            select = FWD_MEM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
            select = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller: forwarding, load-use stall, branch flush, mul/div
// sequencing and stall/flush performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave hz
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic     md_stall;
    logic     md_start;
    logic     lw_stall;
    logic     stall_d_int;
    fwd_sel_t fwd_a, fwd_b;

    forward_sel u_fwd_a (
        .RsE       (hz.Rs1E),
        .RdM       (hz.RdM),
        .RdW       (hz.RdW),
        .RegWriteM (hz.RegWriteM),
        .RegWriteW (hz.RegWriteW),
        .select    (fwd_a)
    );

    forward_sel u_fwd_b (
        .RsE       (hz.Rs2E),
        .RdM       (hz.RdM),
        .RdW       (hz.RdW),
        .RegWriteM (hz.RegWriteM),
        .RegWriteW (hz.RegWriteW),
        .select    (fwd_b)
    );

    assign lw_stall = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

    // On the done cycle the stall drops so the mul/div instruction leaves Execute.
    always_comb begin
        state_d  = state_q;
        md_stall = 1'b0;
        md_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.MdReqE) begin
                    md_start = 1'b1;
                    md_stall = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (hz.MdDoneE) begin
                    state_d = IDLE;
                end else begin
                    md_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        hz.StallF    = 1'b0;
        stall_d_int  = 1'b0;
        hz.StallE    = 1'b0;
        hz.FlushD    = 1'b1;
        hz.FlushE    = 1'b1;
        hz.FlushM    = 1'b1;
        hz.MdStartE  = 1'b0;
        if (!reset) begin
            hz.ForwardAE = fwd_a;
            hz.ForwardBE = fwd_b;
            // A taken branch redirects the PC even when a load-use hazard is present.
            hz.StallF    = md_stall | (lw_stall & ~hz.PCSrcE);
            stall_d_int  = md_stall | lw_stall;
            hz.StallE    = md_stall;
            hz.FlushM    = md_stall;
            hz.FlushD    = hz.PCSrcE & ~md_stall;
            hz.FlushE    = (lw_stall | hz.PCSrcE) & ~md_stall;
            hz.MdStartE  = md_start;
        end
    end

    assign hz.StallD = stall_d_int;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d_int) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hz.PCSrcE) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller with hand-computed expectations.
module tb_hazard_controller;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrce;
        logic [4:0] rdm, rdw;
        logic       rwm, rww, pcsrc, mdreq, mddone, rst;
    } in_t;

    typedef struct packed {
        logic [1:0]       fa, fb;
        logic             sf, sd, se, fd, fe, fm, st;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    logic clk;
    logic reset;

    hazard_controller_if #(.CNT_W(CNT_W)) hz ();

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   id_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    function automatic exp_t ex(input logic [1:0] fa, input logic [1:0] fb,
                                input logic sf, input logic sd, input logic se,
                                input logic fd, input logic fe, input logic fm,
                                input logic st, input int sc, input int fc);
        exp_t e;
        e.fa = fa; e.fb = fb;
        e.sf = sf; e.sd = sd; e.se = se;
        e.fd = fd; e.fe = fe; e.fm = fm; e.st = st;
        e.sc = CNT_W'(sc); e.fc = CNT_W'(fc);
        return e;
    endfunction

    task automatic drive(input in_t v);
        hz.Rs1D       = v.rs1d;
        hz.Rs2D       = v.rs2d;
        hz.Rs1E       = v.rs1e;
        hz.Rs2E       = v.rs2e;
        hz.RdE        = v.rde;
        hz.ResultSrcE = v.rsrce;
        hz.RdM        = v.rdm;
        hz.RdW        = v.rdw;
        hz.RegWriteM  = v.rwm;
        hz.RegWriteW  = v.rww;
        hz.PCSrcE     = v.pcsrc;
        hz.MdReqE     = v.mdreq;
        hz.MdDoneE    = v.mddone;
        reset         = v.rst;
    endtask

    // One cycle of stimulus; the expected response goes to the scoreboard.
    task automatic step(input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(e);
        id_q.push_back(step_no);
        step_no++;
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        exp_t got;
        int   id;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                got.fa = hz.ForwardAE; got.fb = hz.ForwardBE;
                got.sf = hz.StallF;    got.sd = hz.StallD;  got.se = hz.StallE;
                got.fd = hz.FlushD;    got.fe = hz.FlushE;  got.fm = hz.FlushM;
                got.st = hz.MdStartE;
                got.sc = hz.StallCount; got.fc = hz.FlushCount;
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL step%0d: got fa=%b fb=%b sF=%b sD=%b sE=%b fD=%b fE=%b fM=%b st=%b sc=%0d fc=%0d, want fa=%b fb=%b sF=%b sD=%b sE=%b fD=%b fE=%b fM=%b st=%b sc=%0d fc=%0d",
                             id, got.fa, got.fb, got.sf, got.sd, got.se, got.fd, got.fe, got.fm, got.st, got.sc, got.fc,
                             e.fa, e.fb, e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.st, e.sc, e.fc);
                end else begin
                    $display("step%0d ok: fa=%b fb=%b stall=%b%b%b flush=%b%b%b start=%b sc=%0d fc=%0d",
                             id, got.fa, got.fb, got.sf, got.sd, got.se, got.fd, got.fe, got.fm, got.st, got.sc, got.fc);
                end
            end
        end
    end

    initial begin
        in_t v;
        int  wait_cycles;

        v = '0;
        v.rst = 1'b1;
        drive(v);
        repeat (2) @(posedge clk);

        // 0: in reset, outputs forced
        v = '0; v.rst = 1'b1;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        // 1: quiet pipeline
        v = '0;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 2: Memory beats Writeback
        v = '0; v.rs1e = 5; v.rdm = 5; v.rwm = 1; v.rdw = 5; v.rww = 1;
        step(v, ex(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 3: Memory not writing, Writeback forwards to both operands
        v = '0; v.rs1e = 5; v.rs2e = 5; v.rdm = 5; v.rwm = 0; v.rdw = 5; v.rww = 1;
        step(v, ex(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 4: x0 never forwards; B from Writeback
        v = '0; v.rs1e = 0; v.rdm = 0; v.rwm = 1; v.rs2e = 9; v.rdw = 9; v.rww = 1;
        step(v, ex(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 5: load-use on Rs2D
        v = '0; v.rsrce = 2'b01; v.rde = 7; v.rs2d = 7;
        step(v, ex(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        // 6: bubble in Execute, hazard gone
        v = '0; v.rs2d = 7;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // 7: taken branch with load-use
        v = '0; v.rsrce = 2'b01; v.rde = 3; v.rs1d = 3; v.pcsrc = 1;
        step(v, ex(2'b00, 2'b00, 0, 1, 0, 1, 1, 0, 0, 1, 0));
        // 8: quiet
        v = '0;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        // 9: mul/div start
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 2, 1));
        // 10..12: busy, branch during busy gives no flush
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 3, 1));
        v = '0; v.mdreq = 1; v.pcsrc = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 4, 1));
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 5, 2));
        // 13: done
        v = '0; v.mdreq = 1; v.mddone = 1;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6, 2));
        // 14: back-to-back op restarts
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 6, 2));
        // 15: busy
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 7, 2));
        // 16: done
        v = '0; v.mdreq = 1; v.mddone = 1;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 8, 2));
        // 17: done in IDLE ignored
        v = '0; v.mddone = 1;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 8, 2));
        // 18: still idle
        v = '0;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 8, 2));
        // 19: new op
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 8, 2));
        // 20: first busy cycle
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 9, 2));
        // 21: reset in the second busy cycle
        v = '0; v.rst = 1; v.mdreq = 1; v.pcsrc = 1; v.rs1e = 5; v.rdm = 5; v.rwm = 1;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 10, 2));
        // 22: FSM back in IDLE, counters cleared
        v = '0;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 23: stale done ignored
        v = '0; v.mddone = 1;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 24: fresh start after reset
        v = '0; v.mdreq = 1;
        step(v, ex(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0, 0));
        // 25: done
        v = '0; v.mddone = 1;
        step(v, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
